decode_stage_hs: RTL and testbench
==================================

// Module: decode_stage_hs
// PURPOSE
// - RV32I decode stage with valid/ready handshake, replacing the halt-driven decode register.
// - Sits between fetch and execute: splits instruction fields, classifies opcode, forms one sign-extended immediate, flags illegal encodings.
// - Optional skid entry gives registered in_ready and full throughput under backpressure. flush discards in-flight work.
// PARAMETERS
// - XLEN      32  width of imm, in_pc, out_pc (32 or 64; immediates sign-extend to XLEN)
// - DEPTH     2   1 = single output register; 2 = output register + skid entry
// - ENABLE_M  0   1 = OP with funct7=0000001 (MUL/DIV) is legal
// PORTS
// - clk        in   1     clock
// - rstn       in   1     synchronous reset, active-low
// - flush      in   1     discard all held entries (redirect)
// - in_valid   in   1     upstream instruction valid
// - in_ready   out  1     stage accepts in_instr/in_pc this cycle
// - in_instr   in   32    raw instruction
// - in_pc      in   XLEN  instruction PC
// - out_valid  out  1     decoded bundle valid
// - out_ready  in   1     downstream accepts bundle
// - out_pc     out  XLEN  PC of bundle
// - out_imm    out  XLEN  sign-extended immediate (0 for R-type/unknown)
// - out_rd/out_rs1/out_rs2  out  5  register fields, raw bits
// - out_funct3 out  3  / out_funct7  out  7 / out_opcode  out  7   raw fields
// - out_class  out  11    one-hot {system,jal,jalr,branch,lui,alur,store,auipc,alui,fence,load}; 0 if unknown
// - out_illegal out 1     encoding not supported (see rules)
// BEHAVIOUR
// - Reset (rstn=0 at posedge): out_valid=0, in_ready=0 in reset cycle then 1; all payload outputs 0.
// - Transfer in: in_valid&in_ready at posedge. Transfer out: out_valid&out_ready at posedge.
// - Latency: accepted instruction appears on outputs next cycle; no combinational in->out path.
// - DEPTH=1: in_ready = !out_valid | out_ready (combinational from out_ready).
// - DEPTH=2: in_ready = !skid_full (registered). States: EMPTY, ONE (out reg), FULL (out+skid).
//   EMPTY -in-> ONE; ONE -in&!out-> FULL; ONE -out&!in-> EMPTY; ONE in&out -> ONE;
//   FULL -out-> ONE (skid moves to out reg); FULL never accepts. Order strictly preserved.
// - flush: next cycle state EMPTY, out_valid=0; instruction offered in flush cycle is dropped. flush wins over all.
// - Immediates: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0} sign bit inst[31] (bit 12);
//   U {31:12,12'b0} then sign-extend to XLEN; J {31,19:12,20,30:21,0} sign bit inst[31].
// - Class on opcode[6:2]: 00000 load,00011 fence,00100 alui,00101 auipc,01000 store,01100 alur,
//   01101 lui,11000 branch,11001 jalr,11011 jal,11100 system.
// - out_illegal=1 if any: opcode[1:0]!=11; class unknown; load funct3 in {011,110,111};
//   store funct3>=011; branch funct3 in {010,011}; jalr funct3!=000;
//   alur funct7 not 0000000, not (0100000 & funct3 in {000,101}), not (0000001 & ENABLE_M);
//   alui funct3=001 & funct7!=0; alui funct3=101 & funct7 not in {0000000,0100000}.
// - Illegal bundles still flow with out_valid=1; fields decoded as normal; execute raises trap.
// - Payload held stable while out_valid & !out_ready.
// TESTING
// - Stream addi x1,x0,-1 (0xFFF00093) pc=0x100, out_ready=1 -> next cycle out_valid, class=alui, imm=0xFFFFFFFF, rd=1.
// - beq 0xFE000EE3 -> class=branch, imm=0xFFFFFFFC (sign from bit 12), illegal=0.
// - DEPTH=2: 3 back-to-back inputs, out_ready=0 -> 2 accepted, in_ready=0 on cycle 3; release -> in-order output, no loss/dup.
// - 0x02208033 (mul) -> illegal=1 with ENABLE_M=0, 0 with ENABLE_M=1; 0x00000000 -> illegal=1, class=0.
// - flush asserted while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; offered instr never emerges.
// - rstn low mid-stream -> out_valid=0, all payload 0 after reset edge; random valid/ready vs scoreboard 10k instrs.

Source files
------------

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - RV32I decode stage with valid/ready handshake and optional skid entry
// Skid holds the raw instruction; decode runs on the way into the output register.
module decode_stage_hs #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [10:0]     out_class,
  output logic            out_illegal
);

  localparam logic [10:0] C_LOAD   = 11'h001;
  localparam logic [10:0] C_FENCE  = 11'h002;
  localparam logic [10:0] C_ALUI   = 11'h004;
  localparam logic [10:0] C_AUIPC  = 11'h008;
  localparam logic [10:0] C_STORE  = 11'h010;
  localparam logic [10:0] C_ALUR   = 11'h020;
  localparam logic [10:0] C_LUI    = 11'h040;
  localparam logic [10:0] C_BRANCH = 11'h080;
  localparam logic [10:0] C_JALR   = 11'h100;
  localparam logic [10:0] C_JAL    = 11'h200;
  localparam logic [10:0] C_SYSTEM = 11'h400;

  logic            r_live;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [10:0]     r_class;
  logic            r_illegal;

  logic            w_in_fire;
  logic [31:0]     w_src_instr;
  logic [XLEN-1:0] w_src_pc;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [10:0]     w_class;
  logic [XLEN-1:0] w_imm;
  logic            w_bad;
  logic            w_illegal;

  assign in_ready  = (DEPTH >= 2) ? (r_live & ~r_skid_valid)
                                  : (r_live & (~r_out_valid | out_ready));
  assign w_in_fire = in_valid & in_ready;

  // A full skid always drains first, so order is preserved.
  assign w_src_instr = r_skid_valid ? r_skid_instr : in_instr;
  assign w_src_pc    = r_skid_valid ? r_skid_pc    : in_pc;

  assign w_op = w_src_instr[6:0];
  assign w_f3 = w_src_instr[14:12];
  assign w_f7 = w_src_instr[31:25];

  assign w_imm_i = {{(XLEN-12){w_src_instr[31]}}, w_src_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
  assign w_imm_b = {{(XLEN-12){w_src_instr[31]}}, w_src_instr[7], w_src_instr[30:25],
                    w_src_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){w_src_instr[31]}}, w_src_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){w_src_instr[31]}}, w_src_instr[19:12], w_src_instr[20],
                    w_src_instr[30:21], 1'b0};

  always_comb begin
    w_class = 11'd0;
    w_imm   = '0;
    w_bad   = 1'b0;
    if (w_op[1:0] == 2'b11) begin
      case (w_op[6:2])
        5'b00000: begin
          w_class = C_LOAD;
          w_imm   = w_imm_i;
          w_bad   = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
        end
        5'b00011: begin
          w_class = C_FENCE;
          w_imm   = w_imm_i;
        end
        5'b00100: begin
          w_class = C_ALUI;
          w_imm   = w_imm_i;
          w_bad   = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                    ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
        end
        5'b00101: begin
          w_class = C_AUIPC;
          w_imm   = w_imm_u;
        end
        5'b01000: begin
          w_class = C_STORE;
          w_imm   = w_imm_s;
          w_bad   = (w_f3 >= 3'b011);
        end
        5'b01100: begin
          w_class = C_ALUR;
          w_bad   = !((w_f7 == 7'b0000000) ||
                      ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                      ((w_f7 == 7'b0000001) && (ENABLE_M != 0)));
        end
        5'b01101: begin
          w_class = C_LUI;
          w_imm   = w_imm_u;
        end
        5'b11000: begin
          w_class = C_BRANCH;
          w_imm   = w_imm_b;
          w_bad   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
        end
        5'b11001: begin
          w_class = C_JALR;
          w_imm   = w_imm_i;
          w_bad   = (w_f3 != 3'b000);
        end
        5'b11011: begin
          w_class = C_JAL;
          w_imm   = w_imm_j;
        end
        5'b11100: begin
          w_class = C_SYSTEM;
          w_imm   = w_imm_i;
        end
        default: begin
          w_class = 11'd0;
        end
      endcase
    end
  end

  assign w_illegal = w_bad | (w_class == 11'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_live       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr      <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_class      <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_out_valid || out_ready) begin
        if (r_skid_valid || w_in_fire) begin
          r_instr     <= w_src_instr;
          r_pc        <= w_src_pc;
          r_imm       <= w_imm;
          r_class     <= w_class;
          r_illegal   <= w_illegal;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
        r_skid_valid <= 1'b0;
      end else if (w_in_fire && (DEPTH >= 2)) begin
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign out_rd      = r_instr[11:7];
  assign out_rs1     = r_instr[19:15];
  assign out_rs2     = r_instr[24:20];
  assign out_funct3  = r_instr[14:12];
  assign out_funct7  = r_instr[31:25];
  assign out_opcode  = r_instr[6:0];
  assign out_class   = r_class;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb/tb_decode_stage_hs.sv - directed vectors, handshake corner cases and scoreboard for decode_stage_hs
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7, out_opcode;
  logic [10:0] out_class;

  logic        in_valid2, out_ready2, in_ready2, out_valid2, out_illegal2;
  logic [31:0] in_instr2, in_pc2, out_pc2, out_imm2;
  logic [4:0]  out_rd2, out_rs12, out_rs22;
  logic [2:0]  out_funct32;
  logic [6:0]  out_funct72, out_opcode2;
  logic [10:0] out_class2;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .DEPTH(2), .ENABLE_M(0)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_opcode(out_opcode),
    .out_class(out_class), .out_illegal(out_illegal));

  decode_stage_hs #(.XLEN(32), .DEPTH(1), .ENABLE_M(1)) u_dut_m (
    .clk(clk), .rstn(rstn), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr2), .in_pc(in_pc2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pc(out_pc2), .out_imm(out_imm2), .out_rd(out_rd2), .out_rs1(out_rs12), .out_rs2(out_rs22),
    .out_funct3(out_funct32), .out_funct7(out_funct72), .out_opcode(out_opcode2),
    .out_class(out_class2), .out_illegal(out_illegal2));

  typedef struct {
    logic [31:0] instr;
    logic [10:0] cls;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
  } sb_t;

  vec_t vt[16];
  sb_t  q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent, cyc;
    sb_t  e;
    vt[0]  = '{32'hFFF00093, 11'h004, 32'hFFFFFFFF, 1'b0, 5'd1};
    vt[1]  = '{32'hFE000EE3, 11'h080, 32'hFFFFFFFC, 1'b0, 5'd29};
    vt[2]  = '{32'h00000000, 11'h000, 32'h00000000, 1'b1, 5'd0};
    vt[3]  = '{32'h02208033, 11'h020, 32'h00000000, 1'b1, 5'd0};
    vt[4]  = '{32'h123452B7, 11'h040, 32'h12345000, 1'b0, 5'd5};
    vt[5]  = '{32'hFE20AC23, 11'h010, 32'hFFFFFFF8, 1'b0, 5'd24};
    vt[6]  = '{32'h001000EF, 11'h200, 32'h00000800, 1'b0, 5'd1};
    vt[7]  = '{32'h00009067, 11'h100, 32'h00000000, 1'b1, 5'd0};
    vt[8]  = '{32'hFFFFF197, 11'h008, 32'hFFFFF000, 1'b0, 5'd3};
    vt[9]  = '{32'h0000B003, 11'h001, 32'h00000000, 1'b1, 5'd0};
    vt[10] = '{32'h40208033, 11'h020, 32'h00000000, 1'b0, 5'd0};
    vt[11] = '{32'h02005013, 11'h004, 32'h00000020, 1'b1, 5'd0};
    vt[12] = '{32'h00000073, 11'h400, 32'h00000000, 1'b0, 5'd0};
    vt[13] = '{32'h0FF0000F, 11'h002, 32'h000000FF, 1'b0, 5'd0};
    vt[14] = '{32'h00000091, 11'h000, 32'h00000000, 1'b1, 5'd1};
    vt[15] = '{32'h00002063, 11'h080, 32'h00000000, 1'b1, 5'd0};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_instr2 = '0; in_pc2 = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_payload", {out_pc, out_imm, out_class, out_illegal, out_opcode}, 0);
    rstn = 1'b1;
    tick();
    chk("rst_release_in_ready", in_ready, 1);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      in_pc    = 32'h100 + 32'(4 * i);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d_class", i), out_class, vt[i].cls);
      chk($sformatf("v%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("v%0d_illegal", i), out_illegal, vt[i].ill);
      chk($sformatf("v%0d_rd", i), out_rd, vt[i].rd);
    end
    tick();
    chk("drain_empty", out_valid, 0);

    // backpressure: third offer must be refused, then strict order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vt[0].instr; in_pc = 32'hA0;
    tick();
    chk("bp_accept_a_ready", in_ready, 1);
    in_instr = vt[4].instr; in_pc = 32'hB0;
    tick();
    chk("bp_full_ready", in_ready, 0);
    in_instr = vt[6].instr; in_pc = 32'hC0;
    tick();
    chk("bp_refuse_c_ready", in_ready, 0);
    chk("bp_hold_a", {out_valid, out_pc, out_imm}, {1'b1, 32'hA0, 32'hFFFFFFFF});
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", {out_valid, out_pc, out_class}, {1'b1, 32'hB0, 11'h040});
    chk("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", {out_valid, out_pc, out_class}, {1'b1, 32'hC0, 11'h200});
    tick();
    chk("bp_done", out_valid, 0);

    // flush while full with an offer pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vt[0].instr; in_pc = 32'h200;
    tick();
    in_pc = 32'h204;
    tick();
    flush = 1'b1; in_pc = 32'hDDD0;
    tick();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_no_emerge1", out_valid, 0);
    tick();
    chk("flush_no_emerge2", out_valid, 0);

    // reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vt[5].instr; in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    rstn = 1'b0; in_valid = 1'b0;
    tick();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_payload", {out_pc, out_imm, out_class, out_rd, out_rs1, out_illegal}, 0);
    rstn = 1'b1; out_ready = 1'b1;
    tick();
    chk("mrst_release", {in_ready, out_valid}, 2'b10);

    // ENABLE_M=1, DEPTH=1 instance: mul legal, in_ready follows out_ready
    in_valid2 = 1'b1; in_instr2 = vt[3].instr; in_pc2 = 32'h400;
    tick();
    in_valid2 = 1'b0;
    chk("m_valid", out_valid2, 1);
    chk("m_illegal", out_illegal2, 0);
    chk("m_class", out_class2, 11'h020);
    chk("d1_stalled_ready", in_ready2, 0);
    out_ready2 = 1'b1;
    #1;
    chk("d1_comb_ready", in_ready2, 1);
    tick();
    chk("d1_drained", out_valid2, 0);

    // random valid/ready against scoreboard
    sent = 0; cyc = 0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      e.idx     = int'($urandom_range(0, 15));
      in_instr  = vt[e.idx].instr;
      in_pc     = 32'h1000 + 32'(sent * 4);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          sb_t x;
          x = q.pop_front();
          chk("sb_bundle", {out_pc, out_imm, out_class, out_illegal, out_rd},
              {x.pc, vt[x.idx].imm, vt[x.idx].cls, vt[x.idx].ill, vt[x.idx].rd});
        end
      end
      if (in_valid && in_ready) begin
        e.pc = in_pc;
        q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("sb_sent", sent, 10000);
    chk("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
